core_ctrl: RTL and testbench

- Autonomous instruction sequencer for `core`. It replaces the bench-driven kij loop.
- Drives the 34-bit `inst` bus through every kernel position:
  - weight fetch to IFIFO
  - kernel load
  - activation fetch to L0
  - execute
  - OFIFO drain to psum memory
- After the kij loop it runs the psum accumulation pass for every output pixel.
- Sits between the top-level host handshake (start/done) and `core`. Activations and weights for all kij are preloaded in xmem.

---
 rtl/core_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_core_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// core_ctrl: autonomous instruction sequencer for `core`.
//
// Walks every kernel position k (weight fetch -> kernel load -> gap ->
// activation fetch -> execute -> OFIFO drain to psum memory), then runs the
// psum accumulation pass for every output pixel o. All outputs are registered.
// The output values for a cycle are computed from that cycle's state, so
// `inst` and `dbg_state` always describe the same cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset; aborts any sequence at once
//   start        one-cycle pulse, accepted only in IDLE
//   ofifo_valid  OFIFO holds a full output row
//   inst[33:0]   core instruction
//                [33]acc [32]CEN_pmem [31]WEN_pmem [30:20]A_pmem
//                [19]CEN_xmem [18]WEN_xmem [17:7]A_xmem [6]ofifo_rd
//                [5]ififo_wr [4]ififo_rd [3]l0_rd [2]l0_wr [1]execute [0]load
//   sfp_clr      one-cycle clear of the SFU accumulator
//   out_valid    one-cycle pulse: sfp_out holds output pixel out_idx
//   out_idx      output pixel index
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle pulse at the end of the sequence
//   dbg_state    current FSM state (state_t encoding)
//
// Handshake: start is sampled only while IDLE. During DRAIN, ofifo_valid is
// sampled on every rising edge; a high sample makes the following cycle one
// write beat (ofifo_rd=1 plus a pmem write), a low sample makes it a stall
// cycle in which A_pmem holds its last value.

module core_ctrl #(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int KSIZE  = 3,
  parameter int IW     = 6,
  parameter int OW     = 4,
  parameter int W_BASE = 1024,
  parameter int GAP    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        sfp_clr,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic        busy,
  output logic        done,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WFETCH = 4'd1,
    S_KLOAD  = 4'd2,
    S_GAP    = 4'd3,
    S_AFETCH = 4'd4,
    S_EXEC   = 4'd5,
    S_DRAIN  = 4'd6,
    S_ACLR   = 4'd7,
    S_AREAD  = 4'd8,
    S_AWAIT  = 4'd9,
    S_FIN    = 4'd10
  } state_t;

  // All address arithmetic is 11-bit unsigned.
  localparam logic [10:0] L_COL     = 11'(COL);
  localparam logic [10:0] L_IW      = 11'(IW);
  localparam logic [10:0] L_OW      = 11'(OW);
  localparam logic [10:0] L_KSIZE   = 11'(KSIZE);
  localparam logic [10:0] L_WBASE   = 11'(W_BASE);
  localparam logic [10:0] LEN_KIJ   = 11'(KSIZE * KSIZE);
  localparam logic [10:0] LEN_NIJ   = 11'(IW * IW);
  localparam logic [10:0] LEN_ONIJ  = 11'(OW * OW);
  localparam logic [10:0] KLOAD_LEN = 11'(ROW + 2 * COL);
  localparam logic [10:0] EXEC_LEN  = 11'(IW * IW + ROW + COL);
  localparam logic [10:0] GAP_LEN   = 11'(GAP);

  // Idle instruction: both memories disabled and write-protected.
  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  state_t      state, nxt_state;
  logic [10:0] t, nxt_t;
  logic [10:0] k, nxt_k;
  logic [10:0] o, nxt_o;
  logic [10:0] beats;
  logic        nxt_wr;

  logic        acc_n, cen_p_n, wen_p_n, cen_x_n;
  logic [10:0] a_p_n, a_x_n;
  logic        ofifo_rd_n, ififo_wr_n, ififo_rd_n, l0_rd_n, l0_wr_n;
  logic        exec_n, load_n;
  logic [33:0] nxt_inst;
  logic        nxt_clr, nxt_out_valid, nxt_busy, nxt_done;
  logic [3:0]  nxt_out_idx;

  assign dbg_state = state;

  // Beats already written once the current DRAIN cycle completes.
  assign beats = t + {10'd0, inst[6]};

  // Next-state and counter logic.
  always_comb begin
    nxt_state = state;
    nxt_t     = t + 11'd1;
    nxt_k     = k;
    nxt_o     = o;
    nxt_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        nxt_t = 11'd0;
        if (start) begin
          nxt_state = S_WFETCH;
          nxt_k     = 11'd0;
          nxt_o     = 11'd0;
        end
      end
      S_WFETCH: begin
        // col+1 cycles: the extra cycle covers the SRAM read latency.
        if (t == L_COL) begin
          nxt_state = S_KLOAD;
          nxt_t     = 11'd0;
        end
      end
      S_KLOAD: begin
        if (t == KLOAD_LEN - 11'd1) begin
          nxt_state = S_GAP;
          nxt_t     = 11'd0;
        end
      end
      S_GAP: begin
        if (t == GAP_LEN - 11'd1) begin
          nxt_state = S_AFETCH;
          nxt_t     = 11'd0;
        end
      end
      S_AFETCH: begin
        if (t == LEN_NIJ - 11'd1) begin
          nxt_state = S_EXEC;
          nxt_t     = 11'd0;
        end
      end
      S_EXEC: begin
        if (t == EXEC_LEN - 11'd1) begin
          nxt_state = S_DRAIN;
          nxt_t     = 11'd0;
          nxt_wr    = ofifo_valid;
        end
      end
      S_DRAIN: begin
        // In DRAIN, t counts completed write beats rather than cycles.
        nxt_t  = beats;
        nxt_wr = ofifo_valid;
        if (beats == LEN_NIJ + 11'd1) begin
          nxt_t  = 11'd0;
          nxt_wr = 1'b0;
          if (k < LEN_KIJ - 11'd1) begin
            nxt_state = S_WFETCH;
            nxt_k     = k + 11'd1;
          end else begin
            nxt_state = S_ACLR;
            nxt_o     = 11'd0;
          end
        end
      end
      S_ACLR: begin
        nxt_state = S_AREAD;
        nxt_t     = 11'd0;
      end
      S_AREAD: begin
        if (t == LEN_KIJ - 11'd1) begin
          nxt_state = S_AWAIT;
          nxt_t     = 11'd0;
        end
      end
      S_AWAIT: begin
        // t=0 consumes the last read; t=1 presents the finished pixel.
        if (t == 11'd1) begin
          nxt_t = 11'd0;
          if (o < LEN_ONIJ - 11'd1) begin
            nxt_state = S_ACLR;
            nxt_o     = o + 11'd1;
          end else begin
            nxt_state = S_FIN;
          end
        end
      end
      S_FIN: begin
        // start in this cycle is deliberately not looked at.
        nxt_state = S_IDLE;
        nxt_t     = 11'd0;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_t     = 11'd0;
      end
    endcase
  end

  // Output values for the cycle described by the next state.
  always_comb begin
    acc_n         = 1'b0;
    cen_p_n       = 1'b1;
    wen_p_n       = 1'b1;
    a_p_n         = 11'd0;
    cen_x_n       = 1'b1;
    a_x_n         = 11'd0;
    ofifo_rd_n    = 1'b0;
    ififo_wr_n    = 1'b0;
    ififo_rd_n    = 1'b0;
    l0_rd_n       = 1'b0;
    l0_wr_n       = 1'b0;
    exec_n        = 1'b0;
    load_n        = 1'b0;
    nxt_clr       = 1'b0;
    nxt_out_valid = 1'b0;
    nxt_out_idx   = out_idx;
    nxt_busy      = 1'b1;
    nxt_done      = 1'b0;
    case (nxt_state)
      S_IDLE: begin
        nxt_busy = 1'b0;
      end
      S_WFETCH: begin
        ififo_wr_n = 1'b1;
        cen_x_n    = 1'b0;
        a_x_n      = L_WBASE + nxt_k * L_COL
                     + ((nxt_t < L_COL - 11'd1) ? nxt_t : (L_COL - 11'd1));
      end
      S_KLOAD: begin
        ififo_rd_n = 1'b1;
        load_n     = 1'b1;
      end
      S_AFETCH: begin
        l0_wr_n = 1'b1;
        cen_x_n = 1'b0;
        a_x_n   = nxt_t;
      end
      S_EXEC: begin
        l0_rd_n = 1'b1;
        exec_n  = 1'b1;
      end
      S_DRAIN: begin
        if (nxt_wr) begin
          ofifo_rd_n = 1'b1;
          cen_p_n    = 1'b0;
          wen_p_n    = 1'b0;
          a_p_n      = nxt_k * LEN_NIJ
                       + ((nxt_t < LEN_NIJ - 11'd1) ? nxt_t : (LEN_NIJ - 11'd1));
        end else begin
          a_p_n = inst[30:20];
        end
      end
      S_ACLR: begin
        nxt_clr = 1'b1;
      end
      S_AREAD: begin
        // Read psum of kernel position j=t that feeds output pixel o.
        cen_p_n = 1'b0;
        acc_n   = (nxt_t != 11'd0);
        a_p_n   = nxt_t * LEN_NIJ
                  + (nxt_o / L_OW + nxt_t / L_KSIZE) * L_IW
                  + nxt_o % L_OW + nxt_t % L_KSIZE;
      end
      S_AWAIT: begin
        if (nxt_t == 11'd0) begin
          acc_n = 1'b1;
        end else begin
          nxt_out_valid = 1'b1;
          nxt_out_idx   = nxt_o[3:0];
        end
      end
      S_FIN: begin
        nxt_done = 1'b1;
        nxt_busy = 1'b0;
      end
      default: begin
        nxt_busy = 1'b1;
      end
    endcase
    nxt_inst = {acc_n, cen_p_n, wen_p_n, a_p_n, cen_x_n, 1'b1, a_x_n,
                ofifo_rd_n, ififo_wr_n, ififo_rd_n, l0_rd_n, l0_wr_n,
                exec_n, load_n};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      t         <= 11'd0;
      k         <= 11'd0;
      o         <= 11'd0;
      inst      <= INST_IDLE;
      sfp_clr   <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nxt_state;
      t         <= nxt_t;
      k         <= nxt_k;
      o         <= nxt_o;
      inst      <= nxt_inst;
      sfp_clr   <= nxt_clr;
      out_valid <= nxt_out_valid;
      out_idx   <= nxt_out_idx;
      busy      <= nxt_busy;
      done      <= nxt_done;
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Testbench for core_ctrl at default parameters. Expected memory accesses and
// output pixels are generated from the addressing formulas into queues; a
// negedge monitor pops and compares them as the DUT issues them.

module tb_core_ctrl;

  localparam int ROW = 8, COL = 8, KSIZE = 3, IW = 6, OW = 4, W_BASE = 1024;
  localparam int LEN_KIJ = KSIZE * KSIZE;
  localparam int LEN_NIJ = IW * IW;
  localparam int LEN_ONIJ = OW * OW;
  localparam int KIJ_CYCLES = (COL + 1) + (ROW + 2 * COL) + 10 + LEN_NIJ
                              + (LEN_NIJ + ROW + COL) + (LEN_NIJ + 1);
  localparam logic [33:0] INST_RST = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        sfp_clr, out_valid, busy, done;
  logic [3:0]  out_idx, dbg_state;

  core_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .sfp_clr(sfp_clr), .out_valid(out_valid),
    .out_idx(out_idx), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [10:0] xw_q[$];
  logic [10:0] xa_q[$];
  logic [10:0] pw_q[$];
  logic [11:0] pr_q[$];
  logic [3:0]  ov_q[$];
  bit mon_en = 1'b0;
  bit last_valid = 1'b0;
  int valid_mode = 0;
  int n_load, n_exec, n_clr, n_acc, n_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic extra(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0d required=nothing pending (t=%0t)", name, act, $time);
  endtask

  // Reference model: every access the full sequence must make, in order.
  task automatic push_run();
    xw_q.delete(); xa_q.delete(); pw_q.delete(); pr_q.delete(); ov_q.delete();
    for (int kk = 0; kk < LEN_KIJ; kk++) begin
      for (int c = 0; c <= COL; c++)
        xw_q.push_back(11'(W_BASE + kk * COL + ((c < COL - 1) ? c : COL - 1)));
      for (int n = 0; n < LEN_NIJ; n++)
        xa_q.push_back(11'(n));
      for (int b = 0; b <= LEN_NIJ; b++)
        pw_q.push_back(11'(kk * LEN_NIJ + ((b < LEN_NIJ - 1) ? b : LEN_NIJ - 1)));
    end
    for (int px = 0; px < LEN_ONIJ; px++) begin
      for (int j = 0; j < LEN_KIJ; j++) begin
        int row_i, col_i;
        row_i = px / OW + j / KSIZE;
        col_i = px % OW + j % KSIZE;
        pr_q.push_back({1'(j >= 1), 11'(j * LEN_NIJ + row_i * IW + col_i)});
      end
      ov_q.push_back(4'(px));
    end
    n_load = 0; n_exec = 0; n_clr = 0; n_acc = 0; n_done = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) n_done++;
      if (inst[0]) n_load++;
      if (inst[1]) n_exec++;
      if (sfp_clr) n_clr++;
      if (inst[33]) n_acc++;
      if (inst[18] !== 1'b1) check("wen_xmem", 64'(inst[18]), 64'(1));
      if (inst[6] && inst[32]) extra("ofifo_rd_without_write", 64'(inst[30:20]));
      if (inst[5]) begin
        if (xw_q.size() == 0) extra("weight_fetch_extra", 64'(inst[17:7]));
        else check("weight_fetch_addr", 64'({inst[19], inst[17:7]}), 64'({1'b0, xw_q.pop_front()}));
      end
      if (inst[2]) begin
        if (xa_q.size() == 0) extra("act_fetch_extra", 64'(inst[17:7]));
        else check("act_fetch_addr", 64'({inst[19], inst[17:7]}), 64'({1'b0, xa_q.pop_front()}));
      end
      if (!inst[32] && !inst[31]) begin
        if (pw_q.size() == 0) extra("pmem_write_extra", 64'(inst[30:20]));
        else check("pmem_write", 64'({inst[6], last_valid, inst[30:20]}),
                   64'({2'b11, pw_q.pop_front()}));
      end
      if (!inst[32] && inst[31]) begin
        if (pr_q.size() == 0) extra("pmem_read_extra", 64'(inst[30:20]));
        else check("pmem_read_acc_addr", 64'({inst[33], inst[30:20]}), 64'(pr_q.pop_front()));
      end
      if (out_valid) begin
        if (ov_q.size() == 0) extra("out_valid_extra", 64'(out_idx));
        else check("out_idx", 64'(out_idx), 64'(ov_q.pop_front()));
      end
    end
    last_valid = ofifo_valid;
  end

  // ---------------- ofifo_valid driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ofifo_valid = (valid_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(output int at);
    @(posedge clk);
    #1;
    start = 1'b1;
    at = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no done required=done within %0d cycles", budget);
    end
  endtask

  task automatic end_run();
    check("weight_fetch_left", 64'(xw_q.size()), 64'(0));
    check("act_fetch_left", 64'(xa_q.size()), 64'(0));
    check("pmem_write_left", 64'(pw_q.size()), 64'(0));
    check("pmem_read_left", 64'(pr_q.size()), 64'(0));
    check("out_valid_left", 64'(ov_q.size()), 64'(0));
    check("load_cycles", 64'(n_load), 64'(LEN_KIJ * (ROW + 2 * COL)));
    check("exec_cycles", 64'(n_exec), 64'(LEN_KIJ * (LEN_NIJ + ROW + COL)));
    check("sfp_clr_pulses", 64'(n_clr), 64'(LEN_ONIJ));
    check("acc_cycles", 64'(n_acc), 64'(LEN_ONIJ * LEN_KIJ));
    check("done_pulses", 64'(n_done), 64'(1));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_inst", 64'(inst), 64'(INST_RST));
  endtask

  // ---------------- main sequence ----------------
  int c0, d_at, n_late_done, dummy;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst", 64'(inst), 64'(INST_RST));
    check("rst_sfp_clr", 64'(sfp_clr), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_idx", 64'(out_idx), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Run 1: ofifo_valid held high, a second start while busy, a start in FIN
    valid_mode = 0;
    push_run();
    mon_en = 1'b1;
    pulse_start(c0);
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'(1));
    repeat (400) @(posedge clk);
    pulse_start(dummy);
    wait_done(4000, d_at);
    check("done_latency", 64'(d_at - c0), 64'(1 + LEN_KIJ * KIJ_CYCLES + LEN_ONIJ * 12));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_fin_ignored", 64'(busy), 64'(0));
    end_run();

    // Run 2: reset asserted mid-EXEC at k=4
    mon_en = 1'b0;
    pulse_start(c0);
    while (cyc < c0 + 1 + 4 * KIJ_CYCLES + (COL + 1) + (ROW + 2 * COL) + 10 + LEN_NIJ + 20)
      @(posedge clk);
    #2;
    check("exec_before_abort", 64'(inst[1]), 64'(1));
    #1;
    reset = 1'b0;
    #1;
    check("abort_inst_async", 64'(inst), 64'(INST_RST));
    check("abort_busy_async", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    n_late_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) n_late_done++;
    end
    check("no_done_after_abort", 64'(n_late_done), 64'(0));

    // Run 3: fresh start from k=0 with random OFIFO stalls
    valid_mode = 1;
    push_run();
    mon_en = 1'b1;
    pulse_start(c0);
    wait_done(8000, d_at);
    repeat (3) @(negedge clk);
    end_run();
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
